// File: rtl/shared_dmem_arbiter.sv
// shared_dmem_arbiter: round-robin arbiter that serialises NCORES core data
// ports onto one synchronous single-port RAM. Writes take two cycles
// (IDLE, WR). Reads take three cycles (IDLE, RD_ADDR, RD_DATA) and return
// data with a per-core rvalid pulse.
module shared_dmem_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wdata,
    output logic                 ram_we,
    input  logic [DW-1:0]        ram_rdata
);

    localparam int LW = $clog2(NCORES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t             state_q;
    logic [LW-1:0]      last_q;
    logic [LW-1:0]      cur_q;
    logic [NCORES-1:0]  gnt_q;
    logic [NCORES-1:0]  rvalid_q;
    logic               ram_we_q;
    logic [AW-1:0]      ram_addr_q;
    logic [DW-1:0]      ram_wdata_q;

    logic               win_valid_d;
    logic [LW-1:0]      win_d;
    logic [LW-1:0]      scan_idx;

    // Round-robin search: first requester at or after (last+1) mod NCORES.
    always_comb begin
        win_valid_d = 1'b0;
        win_d       = '0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= NCORES; k++) begin
            scan_idx = LW'((32'(last_q) + k) % NCORES);
            if (!win_valid_d && req[scan_idx]) begin
                win_valid_d = 1'b1;
                win_d       = scan_idx;
            end
        end
    end

    // Access sequencer; every output is registered so nothing depends
    // combinationally on req.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            last_q      <= LW'(NCORES - 1);
            cur_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            ram_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_valid_d) begin
                        ram_addr_q  <= addr[win_d*AW +: AW];
                        ram_wdata_q <= wdata[win_d*DW +: DW];
                        cur_q       <= win_d;
                        last_q      <= win_d;
                        gnt_q       <= NCORES'(1) << win_d;
                        if (we[win_d]) begin
                            ram_we_q <= 1'b1;
                            state_q  <= S_WR;
                        end else begin
                            state_q  <= S_RD_ADDR;
                        end
                    end
                end
                S_WR: begin
                    state_q <= S_IDLE;
                end
                S_RD_ADDR: begin
                    rvalid_q <= NCORES'(1) << cur_q;
                    state_q  <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign rdata     = ram_rdata;

endmodule

// File: doc/shared_dmem_arbiter.md
# shared_dmem_arbiter

Round-robin arbiter that lets NCORES processor cores share one synchronous single-port data RAM in the multicore build.

- Each core's data-memory port connects to one requester slot:
  - core MEMCtrl → `we[i]`
  - core DAddress → `addr[i]`
  - core Ddout → `wdata[i]`
  - `rdata` → core Ddin
- The block serialises accesses, drives the RAM, and returns read data with a per-core valid pulse.

## Interface
Parameters:
- `NCORES`, 4: number of requester slots (2..8).
- `AW`, 8: address width.
- `DW`, 8: data width.

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req`  in  NCORES  per-core access request; held high until the access completes.
- `we`  in  NCORES  per-core write (1) / read (0); stable while `req` is high.
- `addr`  in  NCORES*AW  core i at bits [i*AW +: AW]; stable while `req` is high.
- `wdata`  in  NCORES*DW  core i at bits [i*DW +: DW]; stable while `req` is high.
- `gnt`  out  NCORES  one-hot, one-cycle pulse: request accepted (and, for writes, performed).
- `rvalid`  out  NCORES  one-hot, one-cycle pulse: `rdata` is valid for that core.
- `rdata`  out  DW  read data, shared by all cores; equals `ram_rdata`.
- `busy`  out  1  high in every state except IDLE.
- `ram_addr`  out  AW  registered RAM address.
- `ram_wdata`  out  DW  registered RAM write data.
- `ram_we`  out  1  registered RAM write strobe.
- `ram_rdata`  in  DW  RAM read data, valid one cycle after `ram_addr` is presented.

## Operation
- State machine: IDLE, WR, RD_ADDR, RD_DATA.
- **Arbitration:** sampled only in IDLE.
  - Search starts at `(last+1) mod NCORES` and wraps; the first core with `req` high wins.
  - `last` (register) is updated to the winner on every grant.
  - `last` resets to NCORES-1, so core 0 has first priority after reset.
- **IDLE with a winner `w`:**
  - At the clock edge, load `ram_addr`/`ram_wdata` from slot `w` and record `w`.
  - Next state is WR if `we[w]` = 1, otherwise RD_ADDR.
- **IDLE with no request:** remain in IDLE. `ram_we` is 0; `ram_addr`/`ram_wdata` hold their last values.
- **WR:** `ram_we` = 1 and `gnt[w]` = 1 for exactly this cycle → IDLE.
- **RD_ADDR:** `ram_we` = 0, `gnt[w]` = 1 → RD_DATA.
- **RD_DATA:** `ram_rdata` is valid, `rvalid[w]` = 1, `rdata` = `ram_rdata` → IDLE.
- **Requester protocol:**
  - A writer drops `req` on the edge ending its `gnt` cycle.
  - A reader keeps `req` high through `gnt` and drops it on the edge ending its `rvalid` cycle.
  - Because the requester has dropped `req` before the next IDLE cycle, the next IDLE never sees a stale request.
- **Simultaneous requests:** exactly one winner per IDLE cycle. Losers keep `req` high and are served in later IDLE cycles in round-robin order. No core waits more than NCORES-1 other accesses.
- **Output rules:**
  - `gnt` and `rvalid` are one-hot-or-zero.
  - `gnt` and `rvalid` are never both high in the same cycle.
  - `ram_we` is high only in WR.
- **Reset** (asynchronous, any time, including mid-access):
  - State → IDLE; `gnt`, `rvalid`, `ram_we` → 0; `ram_addr`, `ram_wdata` → 0; `last` → NCORES-1.
  - A write in WR is aborted immediately (`ram_we` falls with `RST`).
  - A read in flight produces no `rvalid`.

## Timing
- Write: `req` high in an IDLE cycle (cycle 0) → `gnt` and `ram_we` in cycle 1. The RAM writes on the edge ending cycle 1. The arbiter is back in IDLE in cycle 2.
- Read: `req` in IDLE (cycle 0) → `gnt` in cycle 1 → `rvalid` and `rdata` in cycle 2 → IDLE in cycle 3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- `gnt`, `rvalid`, `busy` and the `ram_*` outputs are decoded from registered state only; there is no combinational path from `req` to any output.
- `rdata` is combinational from `ram_rdata`.

## Test plan
- **Reset:** assert `RST` mid-cycle.
  - Required: all outputs 0 immediately.
  - After release, with `req` = 0, outputs stay 0 and `busy` = 0.
- **Single write then read:** core 2 writes 0xA5 to 0x3C, then reads 0x3C.
  - Write: `gnt[2]` one cycle after request, with `ram_we` = 1, `ram_addr` = 0x3C, `ram_wdata` = 0xA5.
  - Read: `gnt[2]` at +1, `rvalid[2]` at +2, `rdata` = 0xA5.
- **All four cores request reads at once after reset:** grants in order 0,1,2,3. Each `rvalid` 3 cycles apart and one-hot.
- **Round-robin wrap:** core 3 served last; then cores 0 and 3 request together.
  - Required: core 0 granted before core 3.
  - Repeat with core 1 as the last served, cores 0 and 3 requesting: core 3 granted first.
- **Starvation check:** cores 0 and 1 issue back-to-back writes continuously for 40 cycles.
  - Required: the grants strictly alternate 0,1,0,1.
  - No gap between accesses exceeds 2 cycles.
- **Reset mid-access:** pulse `RST` during WR and, separately, during RD_ADDR.
  - Required: `ram_we` drops immediately and no `rvalid` appears.
  - A re-issued request after reset completes normally, with core 0 having top priority.
